// File: rtl/keygen_pkg.sv
// rtl/keygen_pkg.sv - shared state encoding and width helper for the key scheduler
package keygen_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    function automatic int key_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/keygen_sched_rr_arb2.sv
// rtl/keygen_sched_rr_arb2.sv - two-way round-robin grant with registered last winner
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/keygen_sched.sv
// rtl/keygen_sched.sv - round-robin scheduler sharing one RSA key inverter between two requesters
module keygen_sched
    import keygen_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 65535,
    parameter int TW      = 16,
    localparam int KEY_W  = key_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_p,
    input  logic [WIDTH-1:0] req0_q,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_p,
    input  logic [WIDTH-1:0] req1_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_timeout,
    output logic [KEY_W-1:0] rsp_e,
    output logic [KEY_W-1:0] rsp_d,
    output logic             busy,
    output logic             inv_reset,
    output logic [WIDTH-1:0] inv_p,
    output logic [WIDTH-1:0] inv_q,
    input  logic             inv_finish,
    input  logic [KEY_W-1:0] inv_e,
    input  logic [KEY_W-1:0] inv_d
);

    state_t          state;
    state_t          state_next;
    logic [1:0]      arb_req;
    logic [1:0]      grant;
    logic            accept;
    logic [TW-1:0]   cnt;
    logic            timed_out;

    assign arb_req   = (state == S_IDLE && !reset) ? {req1_valid, req0_valid} : 2'b00;
    assign accept    = grant != 2'b00;
    assign timed_out = cnt == TW'(TIMEOUT);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .update (accept),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = state == S_RESP;
    assign busy       = state != S_IDLE;
    // The inverter is held in reset for the whole of our reset as well as the launch pulse.
    assign inv_reset  = reset || (state == S_LAUNCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (inv_finish || timed_out) state_next = S_RESP;
            S_RESP:   if (rsp_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_p       <= '0;
            inv_q       <= '0;
            rsp_id      <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_e       <= '0;
            rsp_d       <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        inv_p  <= grant[1] ? req1_p : req0_p;
                        inv_q  <= grant[1] ? req1_q : req0_q;
                        rsp_id <= grant[1];
                    end
                end
                S_LAUNCH: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    if (inv_finish) begin
                        rsp_e       <= inv_e;
                        rsp_d       <= inv_d;
                        rsp_timeout <= 1'b0;
                    end else if (timed_out) begin
                        rsp_e       <= '0;
                        rsp_d       <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keygen_sched.sv
// tb/tb_keygen_sched.sv - directed self-checking bench for keygen_sched
module tb_keygen_sched;

    localparam int WIDTH = 8;
    localparam int KW    = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_p = '0, req0_q = '0, req1_p = '0, req1_q = '0;
    logic             rsp_valid, rsp_id, rsp_timeout, busy, inv_reset;
    logic             rsp_ready = 1'b0;
    logic [KW-1:0]    rsp_e, rsp_d;
    logic [WIDTH-1:0] inv_p, inv_q;
    logic             inv_finish = 1'b0;
    logic [KW-1:0]    inv_e = '0, inv_d = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keygen_sched #(.WIDTH(WIDTH), .TIMEOUT(8), .TW(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_p(req0_p), .req0_q(req0_q),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_p(req1_p), .req1_q(req1_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_timeout(rsp_timeout), .rsp_e(rsp_e), .rsp_d(rsp_d), .busy(busy),
        .inv_reset(inv_reset), .inv_p(inv_p), .inv_q(inv_q),
        .inv_finish(inv_finish), .inv_e(inv_e), .inv_d(inv_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_any(output int gid, output bit ok, output bit both);
        gid = -1; ok = 1'b0; both = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                gid  = req1_ready ? 1 : 0;
                both = req0_ready && req1_ready;
                ok   = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_wait(input int extra, input logic [KW-1:0] e, input logic [KW-1:0] d);
        step();
        repeat (extra) step();
        inv_finish = 1'b1; inv_e = e; inv_d = d;
        step();
        inv_finish = 1'b0; inv_e = 16'hBEEF; inv_d = 16'hBEEF;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b1; req0_p = 8'd3; req0_q = 8'd11;
        step(); step();
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", req0_ready); end
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_busy_valid got %b%b want 00", busy, rsp_valid); end
        n_checks++; if (inv_reset !== 1'b1) begin n_fail++; $display("FAIL reset_inv_reset got %b want 1", inv_reset); end
        n_checks++; if (inv_p !== 8'd0 || inv_q !== 8'd0 || rsp_e !== 16'd0 || rsp_d !== 16'd0 || rsp_id !== 1'b0 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs got p=%0d q=%0d e=%0d d=%0d id=%b to=%b want all 0", inv_p, inv_q, rsp_e, rsp_d, rsp_id, rsp_timeout);
        end
        req0_valid = 1'b0; reset = 1'b0;
        step();
        n_checks++; if (inv_reset !== 1'b0) begin n_fail++; $display("FAIL post_reset_inv_reset got %b want 0", inv_reset); end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_p = 8'd3; req0_q = 8'd11;
        #1;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready got %b%b want 01", req1_ready, req0_ready); end
        n_checks++; if (inv_reset !== 1'b0) begin n_fail++; $display("FAIL single_inv_reset_T got %b want 0", inv_reset); end
        step();
        req0_valid = 1'b0;
        n_checks++; if (inv_reset !== 1'b1) begin n_fail++; $display("FAIL single_inv_reset_T1 got %b want 1", inv_reset); end
        n_checks++; if (inv_p !== 8'd3 || inv_q !== 8'd11 || busy !== 1'b1) begin n_fail++; $display("FAIL single_launch got p=%0d q=%0d busy=%b want 3 11 1", inv_p, inv_q, busy); end
        step();
        n_checks++; if (inv_reset !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_wait got inv_reset=%b valid=%b want 0 0", inv_reset, rsp_valid); end
        repeat (2) step();
        inv_finish = 1'b1; inv_e = 16'd3; inv_d = 16'd7;
        step();
        inv_finish = 1'b0; inv_e = 16'hBEEF; inv_d = 16'hBEEF;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
        n_checks++; if (rsp_id !== 1'b0 || rsp_e !== 16'd3 || rsp_d !== 16'd7 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp got id=%b e=%0d d=%0d to=%b want 0 3 7 0", rsp_id, rsp_e, rsp_d, rsp_timeout);
        end
        drain();
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_retry();
        int gid; bit ok; bit both;
        req1_valid = 1'b1; req1_p = 8'd5; req1_q = 8'd11;
        accept_any(gid, ok, both);
        req1_valid = 1'b0;
        n_checks++; if (!ok || gid != 1) begin n_fail++; $display("FAIL retry_grant got ok=%b id=%0d want 1 1", ok, gid); end
        n_checks++; if (inv_p !== 8'd5 || inv_q !== 8'd11) begin n_fail++; $display("FAIL retry_pq got %0d %0d want 5 11", inv_p, inv_q); end
        inv_finish = 1'b1; inv_e = 16'hBEEF; inv_d = 16'hBEEF;
        step();
        inv_finish = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL retry_stale_finish got valid=%b busy=%b want 0 1", rsp_valid, busy); end
        step();
        inv_finish = 1'b1; inv_e = 16'd9; inv_d = 16'd9;
        step();
        inv_finish = 1'b0; inv_e = 16'hBEEF; inv_d = 16'hBEEF;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_e !== 16'd9 || rsp_d !== 16'd9) begin
            n_fail++; $display("FAIL retry_rsp got v=%b id=%b e=%0d d=%0d want 1 1 9 9", rsp_valid, rsp_id, rsp_e, rsp_d);
        end
        drain();
    endtask

    task automatic test_tie();
        int gid; bit ok; bit both;
        req0_valid = 1'b1; req0_p = 8'd3; req0_q = 8'd5;
        req1_valid = 1'b1; req1_p = 8'd7; req1_q = 8'd11;
        for (int k = 0; k < 4; k++) begin
            accept_any(gid, ok, both);
            n_checks++; if (!ok || both || gid != (k % 2)) begin n_fail++; $display("FAIL tie_grant_%0d got ok=%b both=%b id=%0d want 1 0 %0d", k, ok, both, gid, k % 2); end
            n_checks++; if (inv_p !== ((k % 2) ? 8'd7 : 8'd3)) begin n_fail++; $display("FAIL tie_p_%0d got %0d want %0d", k, inv_p, (k % 2) ? 7 : 3); end
            if (k % 2) run_wait(1, 16'd7, 16'd43);
            else       run_wait(1, 16'd3, 16'd3);
            n_checks++; if (rsp_id !== 1'(k % 2) || rsp_e !== ((k % 2) ? 16'd7 : 16'd3) || rsp_d !== ((k % 2) ? 16'd43 : 16'd3)) begin
                n_fail++; $display("FAIL tie_rsp_%0d got id=%b e=%0d d=%0d want %0d", k, rsp_id, rsp_e, rsp_d, k % 2);
            end
            drain();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int gid; bit ok; bit both;
        req0_valid = 1'b1; req0_p = 8'd3; req0_q = 8'd11;
        accept_any(gid, ok, both);
        req0_valid = 1'b0;
        n_checks++; if (!ok || gid != 0) begin n_fail++; $display("FAIL bp_grant got ok=%b id=%0d want 1 0", ok, gid); end
        run_wait(0, 16'd3, 16'd7);
        req1_valid = 1'b1; req1_p = 8'd5; req1_q = 8'd11;
        #1;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_e !== 16'd3 || rsp_d !== 16'd7 || req1_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d got v=%b id=%b e=%0d d=%0d rdy1=%b want 1 0 3 7 0", i, rsp_valid, rsp_id, rsp_e, rsp_d, req1_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req1_ready !== 1'b0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_same_cycle got rdy1=%b v=%b want 0 1", req1_ready, rsp_valid); end
        step();
        rsp_ready = 1'b0;
        #1;
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept got %b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        n_checks++; if (inv_p !== 8'd5 || inv_reset !== 1'b1) begin n_fail++; $display("FAIL bp_second_launch got p=%0d rst=%b want 5 1", inv_p, inv_reset); end
        run_wait(0, 16'd9, 16'd9);
        n_checks++; if (rsp_id !== 1'b1 || rsp_e !== 16'd9) begin n_fail++; $display("FAIL bp_second_rsp got id=%b e=%0d want 1 9", rsp_id, rsp_e); end
        drain();
    endtask

    task automatic test_timeout();
        int gid; bit ok; bit both; int n;
        req0_valid = 1'b1; req0_p = 8'd3; req0_q = 8'd11;
        accept_any(gid, ok, both);
        req0_valid = 1'b0;
        step();
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            n++;
            step();
        end
        n_checks++; if (n != 9) begin n_fail++; $display("FAIL timeout_wait_cycles got %0d want 9", n); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_e !== 16'd0 || rsp_d !== 16'd0) begin
            n_fail++; $display("FAIL timeout_rsp got v=%b to=%b e=%0d d=%0d want 1 1 0 0", rsp_valid, rsp_timeout, rsp_e, rsp_d);
        end
        drain();
    endtask

    task automatic test_midreset();
        int gid; bit ok; bit both; bit seen;
        req1_valid = 1'b1; req1_p = 8'd5; req1_q = 8'd11;
        accept_any(gid, ok, both);
        req1_valid = 1'b0;
        step(); step();
        reset = 1'b1; inv_finish = 1'b1; inv_e = 16'd9; inv_d = 16'd9;
        step();
        n_checks++; if (busy !== 1'b0 || inv_reset !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state got busy=%b rst=%b v=%b want 0 1 0", busy, inv_reset, rsp_valid);
        end
        n_checks++; if (rsp_e !== 16'd0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL midreset_clear got e=%0d to=%b want 0 0", rsp_e, rsp_timeout); end
        step();
        n_checks++; if (inv_reset !== 1'b1) begin n_fail++; $display("FAIL midreset_hold got %b want 1", inv_reset); end
        reset = 1'b0; inv_finish = 1'b0;
        step();
        n_checks++; if (inv_reset !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_release got rst=%b busy=%b want 0 0", inv_reset, busy); end
        seen = 1'b0;
        repeat (4) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            step();
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midreset_no_rsp got response want none"); end
        req0_valid = 1'b1; req0_p = 8'd3; req0_q = 8'd11;
        accept_any(gid, ok, both);
        req0_valid = 1'b0;
        n_checks++; if (!ok || gid != 0) begin n_fail++; $display("FAIL midreset_regrant got ok=%b id=%0d want 1 0", ok, gid); end
        run_wait(2, 16'd3, 16'd7);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_e !== 16'd3 || rsp_d !== 16'd7 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL midreset_job got v=%b id=%b e=%0d d=%0d to=%b want 1 0 3 7 0", rsp_valid, rsp_id, rsp_e, rsp_d, rsp_timeout);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_retry();
        test_tie();
        test_backpressure();
        test_timeout();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
